alu_pipe: RTL
=============

# alu_pipe

Parametrised, handshaked successor to the processor's two-stage ALU. Keeps the existing 3-bit opcode encoding and 2-cycle latency for single-cycle ops, widens `ctrl` to 4 bits for logic, shift, unsigned-compare and iterative-multiply ops, and adds valid/ready flow control plus a sticky signed-overflow flag. Sits between the register file read ports and the writeback mux of each distributed processor core.

## Interface
- `DATA_WIDTH`, 32, operand/result width; power of two, ≥ 8.
- `SHAMT_WIDTH`, $clog2(DATA_WIDTH), shift-amount bits taken from `in1`.

- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `ctrl`  in  4  opcode, sampled with operands.
- `in0`, `in1`  in  DATA_WIDTH each  operands.
- `in_valid`  in  1  operands/opcode valid.
- `in_ready`  out  1  block can accept; transfer when `in_valid & in_ready` at a rising edge.
- `out`  out  DATA_WIDTH  result; holds last result between `out_valid` pulses.
- `out_valid`  out  1  one-cycle pulse per accepted op.
- `oflow`  out  1  sticky signed overflow of add/sub.
- `oflow_clear`  in  1  clears `oflow`.

## Operation
- Opcodes; compares output 0/1 in bit 0, upper bits 0; signed = two's complement:
  - 0 `in0`; 1 `in0+in1`; 2 `in0-in1`; 3 `in0==in1`; 4 `in0<in1` signed (strict); 5 `in0>in1` signed (strict); 6 `in1`; 7 zero.
  - 8 AND; 9 OR; 10 XOR; 11 `in0 << sh`; 12 `in0 >> sh` logical; 13 `in0 >>> sh` arithmetic; 14 MUL, low DATA_WIDTH bits of the product (sign-agnostic); 15 `in0<in1` unsigned.
  - `sh = in1[SHAMT_WIDTH-1:0]`; upper `in1` bits ignored.
- Add/sub wrap modulo 2^DATA_WIDTH.
- Signed compares are derived from the subtract sign XOR overflow, so they are correct at extremes.
- Stage 1 registers `ctrl`, `in0`, `in1` and a valid bit on each transfer. Its valid bit is 0 when no transfer occurs.
- Stage 2, single-cycle ops (all except 14): the result is registered into `out` with `out_valid`=1.
- FSM states: IDLE, MUL.
  - IDLE→MUL when stage 1 holds a valid op 14. On entry, load acc=0, mcand=in0, mplier=in1, cnt=0.
  - In MUL, each edge: if `mplier[0]` then acc += mcand; mcand <<= 1; mplier >>= 1; cnt++.
  - On the edge where cnt==DATA_WIDTH-1, write the final acc into `out`, pulse `out_valid`, and return to IDLE.
- `in_ready` = (state==IDLE) & !(stage-1 valid & stage-1 op==14). It is combinational from registers only; no path from `in_valid`.
- When `in_valid` is high and `in_ready` is low, nothing is captured; the source must hold.
- `oflow`:
  - Set on the edge an add/sub result is written, if signed overflow occurred.
  - Cleared by `oflow_clear`.
  - Set wins over clear on the same edge.
  - MUL never sets it.
- Results emerge strictly in acceptance order.

## Timing
- Reset state: `out`=0, `out_valid`=0, `oflow`=0, FSM IDLE, stage-1 valid 0. `in_ready`=1 in the first cycle after reset deasserts.
- Single-cycle op accepted at edge k: `out`/`out_valid` update at edge k+2. `out_valid` is high for exactly one cycle.
  - Throughput: one op per cycle.
- MUL accepted at edge k:
  - `in_ready` is low from the cycle after edge k.
  - FSM enters MUL at edge k+1.
  - Result and `out_valid` arrive at edge k+1+DATA_WIDTH.
  - `in_ready` rises after that edge, so the next transfer is no earlier than edge k+2+DATA_WIDTH.
- Single-cycle op accepted at k-1, followed by MUL at k: its result is at k+1, with no collision.
- Reset asserted mid-MUL: the multiply is abandoned, no `out_valid`, and all state returns to reset values at that edge.
- `oflow_clear` and `in_valid` are independent. The clear takes effect at the edge it is sampled.

## Test plan
- Reset, then continuous valid single-cycle stream:
  - add 5+7 → `out`=12.
  - sub 3-5 → `out`=0xFFFFFFFE.
  - eq 9,9 → 1.
  - Each result arrives 2 edges after transfer, with back-to-back `out_valid`.
- Signed extremes:
  - op4 0x80000000 vs 1 → 1.
  - op5 0x7FFFFFFF vs 0xFFFFFFFF → 1.
  - op15 1 vs 0xFFFFFFFF → 1.
  - add 0x7FFFFFFF+1 → `out`=0x80000000 and `oflow`=1.
  - `oflow` persists until `oflow_clear`.
  - Simultaneous overflow and clear → `oflow` stays 1.
- Shifts:
  - op13 0x80000000 by in1=0x21 → sh=1, `out`=0xC0000000.
  - op11 1 by 31 → 0x80000000.
  - op12 0x80000000 by 31 → 1.
- MUL 0xFFFFFFFF × 3 → `out`=0xFFFFFFFD at edge k+33.
  - `in_ready` is low for cycles k+1..k+33.
  - `in_valid` held high throughout is accepted only at edge k+34.
- Add accepted one cycle before MUL 6×7 → `out_valid` for the add at k+1 and for 42 at k+33, in order.
- Reset asserted at cycle k+10 of a MUL → no `out_valid`; `in_ready`=1 after reset; next add completes normally.

Source files
------------

// File: rtl/alu_pipe_if.sv
// Operand/result bus of alu_pipe: operands and opcode in, a single result
// and the sticky overflow flag out. The source drives the master side.
interface alu_pipe_if #(
  parameter int DATA_WIDTH = 32
);
  logic [3:0]            ctrl;
  logic [DATA_WIDTH-1:0] in0;
  logic [DATA_WIDTH-1:0] in1;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out;
  logic                  out_valid;
  logic                  oflow;
  logic                  oflow_clear;

  modport master (
    output ctrl, in0, in1, in_valid, oflow_clear,
    input  in_ready, out, out_valid, oflow
  );

  modport slave (
    input  ctrl, in0, in1, in_valid, oflow_clear,
    output in_ready, out, out_valid, oflow
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage handshaked ALU: 15 single-cycle ops with 2-edge latency plus an
// iterative shift-add multiplier that stalls the input while it runs.
module alu_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic      clk,
  input  logic      reset,
  alu_pipe_if.slave bus,
  output logic      dbg_state_o
);

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  localparam logic [3:0]             OP_MUL   = 4'd14;
  localparam logic [SHAMT_WIDTH-1:0] CNT_LAST = SHAMT_WIDTH'(DATA_WIDTH - 1);
  localparam int                     MSB      = DATA_WIDTH - 1;

  // Handshake: a transfer happens at a rising edge where in_valid & in_ready;
  // in_ready depends on registers only, and a source seeing in_ready low
  // must hold its operands until a transfer occurs.
  logic in_ready_w;
  logic xfer;

  logic                  s1_valid_q, s1_valid_d;
  logic [3:0]            s1_ctrl_q, s1_ctrl_d;
  logic [DATA_WIDTH-1:0] s1_in0_q, s1_in0_d;
  logic [DATA_WIDTH-1:0] s1_in1_q, s1_in1_d;

  logic                  r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] r_q, r_d;
  logic                  r_ovf_q, r_ovf_d;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic [DATA_WIDTH-1:0]  mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0]  mplier_q, mplier_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  acc_step;
  logic                   mul_done;

  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  oflow_q, oflow_d;

  logic [DATA_WIDTH-1:0]  sum, diff, res;
  logic [SHAMT_WIDTH-1:0] sh;
  logic                   add_ovf, sub_ovf, eq, lt_s, gt_s, lt_u, res_ovf;

  assign in_ready_w = (state_q == IDLE) & ~(s1_valid_q & (s1_ctrl_q == OP_MUL));
  assign xfer       = bus.in_valid & in_ready_w;

  always_comb begin
    s1_valid_d = xfer;
    s1_ctrl_d  = s1_ctrl_q;
    s1_in0_d   = s1_in0_q;
    s1_in1_d   = s1_in1_q;
    if (xfer) begin
      s1_ctrl_d = bus.ctrl;
      s1_in0_d  = bus.in0;
      s1_in1_d  = bus.in1;
    end
  end

  // Signed compares come from the subtract sign corrected by overflow.
  always_comb begin
    sum     = s1_in0_q + s1_in1_q;
    diff    = s1_in0_q - s1_in1_q;
    sh      = s1_in1_q[SHAMT_WIDTH-1:0];
    add_ovf = (s1_in0_q[MSB] == s1_in1_q[MSB]) && (sum[MSB] != s1_in0_q[MSB]);
    sub_ovf = (s1_in0_q[MSB] != s1_in1_q[MSB]) && (diff[MSB] != s1_in0_q[MSB]);
    eq      = (s1_in0_q == s1_in1_q);
    lt_s    = diff[MSB] ^ sub_ovf;
    gt_s    = ~lt_s & ~eq;
    lt_u    = (s1_in0_q < s1_in1_q);
    res_ovf = 1'b0;
    res     = '0;
    unique case (s1_ctrl_q)
      4'd0:  res = s1_in0_q;
      4'd1:  begin res = sum;  res_ovf = add_ovf; end
      4'd2:  begin res = diff; res_ovf = sub_ovf; end
      4'd3:  res = DATA_WIDTH'(eq);
      4'd4:  res = DATA_WIDTH'(lt_s);
      4'd5:  res = DATA_WIDTH'(gt_s);
      4'd6:  res = s1_in1_q;
      4'd7:  res = '0;
      4'd8:  res = s1_in0_q & s1_in1_q;
      4'd9:  res = s1_in0_q | s1_in1_q;
      4'd10: res = s1_in0_q ^ s1_in1_q;
      4'd11: res = s1_in0_q << sh;
      4'd12: res = s1_in0_q >> sh;
      4'd13: res = $signed(s1_in0_q) >>> sh;
      4'd14: res = '0;
      4'd15: res = DATA_WIDTH'(lt_u);
      default: res = '0;
    endcase
    r_valid_d = s1_valid_q & (s1_ctrl_q != OP_MUL);
    r_d       = r_valid_d ? res : r_q;
    r_ovf_d   = r_valid_d & res_ovf;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    mul_done = 1'b0;
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    unique case (state_q)
      IDLE: begin
        if (s1_valid_q && (s1_ctrl_q == OP_MUL)) begin
          state_d  = MUL;
          acc_d    = '0;
          mcand_d  = s1_in0_q;
          mplier_d = s1_in1_q;
          cnt_d    = '0;
        end
      end
      MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          mul_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A single-cycle result and the multiply result never land on the same
  // edge because in_ready blocks new ops for the whole multiply.
  always_comb begin
    out_d       = out_q;
    out_valid_d = 1'b0;
    oflow_d     = oflow_q;
    if (bus.oflow_clear) oflow_d = 1'b0;
    if (r_valid_q) begin
      out_d       = r_q;
      out_valid_d = 1'b1;
      if (r_ovf_q) oflow_d = 1'b1;
    end else if (mul_done) begin
      out_d       = acc_step;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_ctrl_q   <= '0;
      s1_in0_q    <= '0;
      s1_in1_q    <= '0;
      r_valid_q   <= 1'b0;
      r_q         <= '0;
      r_ovf_q     <= 1'b0;
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      oflow_q     <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_ctrl_q   <= s1_ctrl_d;
      s1_in0_q    <= s1_in0_d;
      s1_in1_q    <= s1_in1_d;
      r_valid_q   <= r_valid_d;
      r_q         <= r_d;
      r_ovf_q     <= r_ovf_d;
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      oflow_q     <= oflow_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.oflow     = oflow_q;
  assign dbg_state_o   = state_q;

endmodule
